// File: rtl/apb_arbiter_2x1.sv
// Two-requester APB arbiter: round-robin grant onto a single downstream APB port,
// with an ACCESS-phase timeout that turns a hung slave into a pslverr response.
module apb_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_psel,
    input  logic                  s0_penable,
    input  logic                  s0_pwrite,
    input  logic [ADDR_WIDTH-1:0] s0_paddr,
    input  logic [DATA_WIDTH-1:0] s0_pwdata,
    output logic                  s0_pready,
    output logic [DATA_WIDTH-1:0] s0_prdata,
    output logic                  s0_pslverr,
    input  logic                  s1_psel,
    input  logic                  s1_penable,
    input  logic                  s1_pwrite,
    input  logic [ADDR_WIDTH-1:0] s1_paddr,
    input  logic [DATA_WIDTH-1:0] s1_pwdata,
    output logic                  s1_pready,
    output logic [DATA_WIDTH-1:0] s1_prdata,
    output logic                  s1_pslverr,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,
    input  logic [DATA_WIDTH-1:0] m_prdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            req_psel;
    logic [1:0]            req_penable;
    logic [1:0]            req_pwrite;
    logic [ADDR_WIDTH-1:0] req_paddr  [2];
    logic [DATA_WIDTH-1:0] req_pwdata [2];

    assign req_psel      = {s1_psel, s0_psel};
    assign req_penable   = {s1_penable, s0_penable};
    assign req_pwrite    = {s1_pwrite, s0_pwrite};
    assign req_paddr[0]  = s0_paddr;
    assign req_paddr[1]  = s1_paddr;
    assign req_pwdata[0] = s0_pwdata;
    assign req_pwdata[1] = s1_pwdata;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  m_psel_q, m_psel_d;
    logic                  m_penable_q, m_penable_d;
    logic                  m_pwrite_q, m_pwrite_d;
    logic [ADDR_WIDTH-1:0] m_paddr_q, m_paddr_d;
    logic [DATA_WIDTH-1:0] m_pwdata_q, m_pwdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic [1:0]            pready_q, pready_d;
    logic [1:0]            pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q [2];
    logic [DATA_WIDTH-1:0] prdata_d [2];

    logic                  sel;
    logic                  finish;
    logic                  gnt_active;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        pready_d    = '0;
        pslverr_d   = '0;
        prdata_d[0] = '0;
        prdata_d[1] = '0;
        sel         = 1'b0;
        finish      = 1'b0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        // Requester is still in its access phase and can accept the pready pulse.
        gnt_active  = req_psel[gnt_q] & req_penable[gnt_q];

        case (state_q)
            ST_IDLE: begin
                if (|req_psel) begin
                    sel         = (&req_psel) ? ~last_q : req_psel[1];
                    gnt_d       = sel;
                    m_pwrite_d  = req_pwrite[sel];
                    m_paddr_d   = req_paddr[sel];
                    m_pwdata_d  = req_pwdata[sel];
                    m_psel_d    = 1'b1;
                    m_penable_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                m_penable_d = 1'b1;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_pready) begin
                    rsp_data = m_pwrite_q ? '0 : m_prdata;
                    rsp_err  = m_pslverr;
                    finish   = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    rsp_err = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (finish) begin
                    resp_data_d = rsp_data;
                    resp_err_d  = rsp_err;
                    m_psel_d    = 1'b0;
                    m_penable_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                    // Fast path: requester already waiting, pulse on the first RESP cycle.
                    if (gnt_active) begin
                        pready_d[gnt_q]  = 1'b1;
                        prdata_d[gnt_q]  = rsp_data;
                        pslverr_d[gnt_q] = rsp_err;
                    end
                end
            end
            ST_RESP: begin
                if (pready_q[gnt_q] || !req_psel[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = ST_IDLE;
                end else if (gnt_active) begin
                    pready_d[gnt_q]  = 1'b1;
                    prdata_d[gnt_q]  = resp_data_q;
                    pslverr_d[gnt_q] = resp_err_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            pready_q    <= '0;
            pslverr_q   <= '0;
            prdata_q[0] <= '0;
            prdata_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q[0] <= prdata_d[0];
            prdata_q[1] <= prdata_d[1];
        end
    end

    assign m_psel     = m_psel_q;
    assign m_penable  = m_penable_q;
    assign m_pwrite   = m_pwrite_q;
    assign m_paddr    = m_paddr_q;
    assign m_pwdata   = m_pwdata_q;
    assign s0_pready  = pready_q[0];
    assign s0_prdata  = prdata_q[0];
    assign s0_pslverr = pslverr_q[0];
    assign s1_pready  = pready_q[1];
    assign s1_prdata  = prdata_q[1];
    assign s1_pslverr = pslverr_q[1];

endmodule
